// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states and the result FIFO entry.
package alu_seq_pkg;

  localparam int W     = 16;
  localparam int OPC_W = 3;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  // One completed ALU operation as stored in the result FIFO.
  typedef struct packed {
    logic [W-1:0]     f;
    logic             zer;
    logic             neg;
    logic [OPC_W-1:0] opc;
  } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// First-word-fall-through result FIFO. The head is presented combinationally from
// storage and forced to zero while empty; pops on an empty FIFO are ignored.
module alu_res_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The sequencer only accepts a command when there is room, so a push into a full FIFO is a bug.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end and result back-end around the 16-bit combinational ALU.
// A command is registered onto the ALU inputs, the ALU output is captured one
// cycle later into the result FIFO, and an optional chain bit reuses the last
// result as operand M. W must match the package width used by res_entry_t.
module alu_cmd_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_opc,
  input  logic [W-1:0] cmd_m,
  input  logic [W-1:0] cmd_n,
  input  logic         cmd_c,
  input  logic         cmd_chain,
  output logic [W-1:0] alu_m,
  output logic [W-1:0] alu_n,
  output logic [2:0]   alu_opc,
  output logic         alu_c,
  input  logic [W-1:0] alu_f,
  input  logic         alu_zer,
  input  logic         alu_neg,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_f,
  output logic         res_zer,
  output logic         res_neg,
  output logic [2:0]   res_opc,
  output logic         busy,
  output logic [15:0]  op_count
);

  import alu_seq_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state;
  logic [W-1:0]     last_f;
  logic             push;
  res_entry_t       push_entry;
  res_entry_t       head;
  logic [CNT_W-1:0] fifo_count;

  assign cmd_ready  = (state == IDLE) && (fifo_count < CNT_W'(DEPTH));
  assign busy       = (state == EXEC);
  assign push       = (state == EXEC);
  assign push_entry = '{f: alu_f, zer: alu_zer, neg: alu_neg, opc: alu_opc};

  assign res_f   = head.f;
  assign res_zer = head.zer;
  assign res_neg = head.neg;
  assign res_opc = head.opc;

  // Two-state sequencer: IDLE registers an accepted command onto the ALU, EXEC retires its result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_m    <= '0;
      alu_n    <= '0;
      alu_opc  <= '0;
      alu_c    <= 1'b0;
      last_f   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_m   <= cmd_chain ? last_f : cmd_m;
            alu_n   <= cmd_n;
            alu_opc <= cmd_opc;
            alu_c   <= cmd_c;
            state   <= EXEC;
          end
        end
        EXEC: begin
          last_f   <= alu_f;
          op_count <= op_count + 16'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_res_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (res_entry_t)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (res_ready),
    .head      (head),
    .valid     (res_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural adder ALU stub and
// a queue-based model of expected results.
module tb_alu_cmd_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] f;
    logic        zer;
    logic        neg;
    logic [2:0]  opc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_opc;
  logic [W-1:0] cmd_m;
  logic [W-1:0] cmd_n;
  logic         cmd_c;
  logic         cmd_chain;
  logic [W-1:0] alu_m;
  logic [W-1:0] alu_n;
  logic [2:0]   alu_opc;
  logic         alu_c;
  logic [W-1:0] alu_f;
  logic         alu_zer;
  logic         alu_neg;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_f;
  logic         res_zer;
  logic         res_neg;
  logic [2:0]   res_opc;
  logic         busy;
  logic [15:0]  op_count;

  int          checks;
  int          errors;
  exp_t        exp_q[$];
  logic [15:0] model_last;
  logic [15:0] model_count;

  alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opc   (cmd_opc),
    .cmd_m     (cmd_m),
    .cmd_n     (cmd_n),
    .cmd_c     (cmd_c),
    .cmd_chain (cmd_chain),
    .alu_m     (alu_m),
    .alu_n     (alu_n),
    .alu_opc   (alu_opc),
    .alu_c     (alu_c),
    .alu_f     (alu_f),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_f     (res_f),
    .res_zer   (res_zer),
    .res_neg   (res_neg),
    .res_opc   (res_opc),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Behavioural ALU stub: add with carry, flags derived from the sum.
  assign alu_f   = alu_m + alu_n + {15'd0, alu_c};
  assign alu_zer = (alu_f == 16'h0000);
  assign alu_neg = alu_f[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_last  = 16'h0000;
    model_count = 16'h0000;
  endtask

  // Offer one command, wait (bounded) for acceptance, then let it execute.
  task automatic apply_stimulus(input string tag, input logic [2:0] opc, input logic [15:0] m,
                                input logic [15:0] n, input logic c, input logic chain,
                                input bit pop_on_close);
    logic [15:0] m_eff;
    logic [15:0] f;
    int waited;
    cmd_valid = 1'b1;
    cmd_opc   = opc;
    cmd_m     = m;
    cmd_n     = n;
    cmd_c     = c;
    cmd_chain = chain;
    waited    = 0;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      check_output({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      tick();
      cmd_valid = 1'b0;
      m_eff = chain ? model_last : m;
      f     = m_eff + n + 16'(c);
      exp_q.push_back('{f: f, zer: (f == 16'h0000), neg: f[15], opc: opc});
      check_output({tag, "_busy"},      32'(busy), 32'd1);
      check_output({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check_output({tag, "_alu_m"},     32'(alu_m), 32'(m_eff));
      check_output({tag, "_alu_n"},     32'(alu_n), 32'(n));
      check_output({tag, "_alu_opc"},   32'(alu_opc), 32'(opc));
      check_output({tag, "_alu_c"},     32'(alu_c), 32'(c));
      if (pop_on_close) begin
        check_output({tag, "_old_head"}, 32'(res_f), 32'(exp_q[0].f));
        res_ready = 1'b1;
      end
      tick();
      res_ready = 1'b0;
      if (pop_on_close) void'(exp_q.pop_front());
      model_last  = f;
      model_count = model_count + 16'd1;
      check_output({tag, "_busy_done"}, 32'(busy), 32'd0);
      check_output({tag, "_op_count"},  32'(op_count), 32'(model_count));
      check_output({tag, "_res_valid"}, 32'(res_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check_output({tag, "_head_f"}, 32'(res_f), 32'(exp_q[0].f));
    end
  endtask

  // Wait (bounded) for a result, compare the head with the oldest expected entry, pop it.
  task automatic check_pop(input string tag);
    int waited;
    exp_t e;
    waited = 0;
    while (!res_valid && waited < 20) begin
      tick();
      waited++;
    end
    check_output({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_output({tag, "_model_empty"}, 32'(res_valid), 32'd0);
    end else if (res_valid) begin
      e = exp_q.pop_front();
      check_output({tag, "_res_f"},   32'(res_f), 32'(e.f));
      check_output({tag, "_res_zer"}, 32'(res_zer), 32'(e.zer));
      check_output({tag, "_res_neg"}, 32'(res_neg), 32'(e.neg));
      check_output({tag, "_res_opc"}, 32'(res_opc), 32'(e.opc));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_opc   = 3'd5;
    cmd_m     = 16'h1111;
    cmd_n     = 16'h2222;
    cmd_c     = 1'b1;
    cmd_chain = 1'b0;
    res_ready = 1'b0;

    // Reset held for two edges with a command offered.
    tick();
    tick();
    check_output("rst_alu_m",     32'(alu_m), 32'd0);
    check_output("rst_alu_n",     32'(alu_n), 32'd0);
    check_output("rst_alu_opc",   32'(alu_opc), 32'd0);
    check_output("rst_alu_c",     32'(alu_c), 32'd0);
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_res_f",     32'(res_f), 32'd0);
    check_output("rst_res_flags", 32'({res_zer, res_neg, res_opc}), 32'd0);
    check_output("rst_busy",      32'(busy), 32'd0);
    check_output("rst_op_count",  32'(op_count), 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check_output("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rel_busy",      32'(busy), 32'd0);

    // Single operation.
    apply_stimulus("s2", 3'd3, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0);
    check_output("s2_res_f",   32'(res_f), 32'h1236);
    check_output("s2_res_zer", 32'(res_zer), 32'd0);
    check_output("s2_res_neg", 32'(res_neg), 32'd0);
    check_output("s2_res_opc", 32'(res_opc), 32'd3);
    check_output("s2_op_count", 32'(op_count), 32'd1);
    check_pop("s2");

    // Chaining through the previous result.
    apply_stimulus("s3a", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check_output("s3a_res_f",   32'(res_f), 32'h8000);
    check_output("s3a_res_neg", 32'(res_neg), 32'd1);
    check_pop("s3a");
    apply_stimulus("s3b", 3'd1, 16'hAAAA, 16'h8000, 1'b0, 1'b1, 1'b0);
    check_output("s3b_alu_m",   32'(alu_m), 32'h8000);
    check_output("s3b_res_f",   32'(res_f), 32'h0000);
    check_output("s3b_res_zer", 32'(res_zer), 32'd1);
    check_output("s3b_res_neg", 32'(res_neg), 32'd0);
    check_pop("s3b");

    // Backpressure: two commands fill the FIFO, the third is held until a pop.
    apply_stimulus("s4a", 3'd2, 16'h1111, 16'h0010, 1'b0, 1'b0, 1'b0);
    apply_stimulus("s4b", 3'd4, 16'h2222, 16'h0020, 1'b1, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_opc   = 3'd6;
    cmd_m     = 16'h3333;
    cmd_n     = 16'h0030;
    cmd_c     = 1'b0;
    cmd_chain = 1'b0;
    tick();
    tick();
    check_output("s4_stall_ready", 32'(cmd_ready), 32'd0);
    check_output("s4_stall_busy",  32'(busy), 32'd0);
    check_output("s4_stall_count", 32'(op_count), 32'(model_count));
    check_output("s4_hold_alu_m",  32'(alu_m), 32'h2222);
    check_pop("s4_pop1");
    check_output("s4_ready_again", 32'(cmd_ready), 32'd1);
    apply_stimulus("s4c", 3'd6, 16'h3333, 16'h0030, 1'b0, 1'b0, 1'b0);
    check_pop("s4_pop2");
    check_pop("s4_pop3");
    check_output("s4_drained", 32'(res_valid), 32'd0);

    // Push and pop on the same edge keep one entry and advance the head.
    apply_stimulus("s5a", 3'd1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
    apply_stimulus("s5b", 3'd2, 16'h0F00, 16'h00F0, 1'b1, 1'b0, 1'b1);
    check_output("s5_head_f", 32'(res_f), 32'h0FF1);
    check_pop("s5");
    check_output("s5_one_entry", 32'(res_valid), 32'd0);

    // Reset during EXEC discards the in-flight operation.
    cmd_valid = 1'b1;
    cmd_opc   = 3'd0;
    cmd_m     = 16'h0005;
    cmd_n     = 16'h0005;
    cmd_c     = 1'b0;
    cmd_chain = 1'b0;
    tick();
    check_output("s6_in_exec", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check_output("s6_res_valid", 32'(res_valid), 32'd0);
    check_output("s6_op_count",  32'(op_count), 32'd0);
    check_output("s6_busy",      32'(busy), 32'd0);
    apply_stimulus("s6", 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0);
    check_output("s6_res_f", 32'(res_f), 32'h000A);
    check_pop("s6");

    // Chain straight after reset uses a zero previous result.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    apply_stimulus("s7", 3'd0, 16'hFFFF, 16'h0003, 1'b0, 1'b1, 1'b0);
    check_output("s7_res_f", 32'(res_f), 32'h0003);
    check_pop("s7");

    // Randomised traffic against the model.
    for (int i = 0; i < 24; i++) begin
      if (exp_q.size() == DEPTH) check_pop("rnd_full");
      apply_stimulus("rnd", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (exp_q.size() != 0) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) check_pop("rnd");
    end
    while (exp_q.size() != 0) check_pop("rnd_drain");
    check_output("rnd_empty", 32'(res_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
